// File: rtl/l1_cache_pkg.sv
// Shared definitions for the L1 cache controller.
//   - default tag/index widths of the 32-bit byte address split
//   - bit positions inside the 24-bit tag entry {valid, dirty, tag}
//   - controller FSM state encoding
package l1_cache_pkg;

    localparam int TAG_W     = 22;  // addr[31:10]
    localparam int IDX_W     = 8;   // addr[9:2]
    localparam int ENTRY_W   = 24;  // {valid, dirty, tag}
    localparam int VALID_BIT = 23;
    localparam int DIRTY_BIT = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRBACK,
        ST_REFILL,
        ST_RESP
    } state_t;

endpackage

// File: rtl/l1_sat_counter.sv
// 16-bit saturating event counter.
//   clk   : clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : count one event on this rising edge
//   count : current value, holds at 0xFFFF once reached
module l1_sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped L1 cache controller, one 64-bit word per line.
//   CPU side : cpu_req_valid/we/addr/wdata in, cpu_req_ready, cpu_resp_valid,
//              cpu_rdata out (resp_valid is a one-cycle completion pulse)
//   Array    : arr_addr out, arr_tag_valid_dirty/arr_data in (combinational
//              read), arr_wr_l2 (refill) / arr_wr_cpu (CPU write) strobes with
//              arr_tag_update, arr_fill_data, arr_wdata
//   L2 side  : l2_req_valid/we/addr/wdata out (held until l2_ack),
//              l2_ack/l2_rdata in
//   Stats    : hit_cnt (first-pass hits), miss_cnt, both saturating
module l1_cache_ctrl
    import l1_cache_pkg::state_t, l1_cache_pkg::ST_IDLE, l1_cache_pkg::ST_LOOKUP,
           l1_cache_pkg::ST_WRBACK, l1_cache_pkg::ST_REFILL, l1_cache_pkg::ST_RESP,
           l1_cache_pkg::ENTRY_W, l1_cache_pkg::VALID_BIT, l1_cache_pkg::DIRTY_BIT;
#(
    parameter int TAG_W = l1_cache_pkg::TAG_W,
    parameter int IDX_W = l1_cache_pkg::IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req_valid,
    input  logic               cpu_req_we,
    input  logic [31:0]        cpu_addr,
    input  logic [63:0]        cpu_wdata,
    output logic               cpu_req_ready,
    output logic               cpu_resp_valid,
    output logic [63:0]        cpu_rdata,
    output logic [31:0]        arr_addr,
    input  logic [ENTRY_W-1:0] arr_tag_valid_dirty,
    input  logic [63:0]        arr_data,
    output logic               arr_wr_l2,
    output logic               arr_wr_cpu,
    output logic [ENTRY_W-1:0] arr_tag_update,
    output logic [63:0]        arr_fill_data,
    output logic [63:0]        arr_wdata,
    output logic               l2_req_valid,
    output logic               l2_req_we,
    output logic [31:0]        l2_addr,
    output logic [63:0]        l2_wdata,
    input  logic               l2_ack,
    input  logic [63:0]        l2_rdata,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt
);

    state_t             state_reg;
    logic [31:0]        addr_reg;
    logic               we_reg;
    logic [63:0]        wdata_reg;
    logic               replay_reg;
    logic               ready_reg;
    logic               resp_valid_reg;
    logic [63:0]        rdata_reg;
    logic               wr_l2_reg;
    logic               wr_cpu_reg;
    logic [ENTRY_W-1:0] tag_update_reg;
    logic [63:0]        fill_data_reg;
    logic [63:0]        arr_wdata_reg;
    logic               l2_req_valid_reg;
    logic               l2_req_we_reg;
    logic [31:0]        l2_addr_reg;
    logic [63:0]        l2_wdata_reg;

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   old_tag;
    logic               lookup_active;
    logic               hit;
    logic               old_dirty;

    assign req_tag   = addr_reg[31 -: TAG_W];
    assign req_idx   = addr_reg[IDX_W+1:2];
    assign old_tag   = arr_tag_valid_dirty[TAG_W-1:0];
    assign hit       = arr_tag_valid_dirty[VALID_BIT] && (old_tag == req_tag);
    assign old_dirty = arr_tag_valid_dirty[VALID_BIT] && arr_tag_valid_dirty[DIRTY_BIT];

    // The cycle after a refill the fill strobe is still writing the array, so
    // the tag seen then is stale; the replay lookup is evaluated one cycle on.
    assign lookup_active = (state_reg == ST_LOOKUP) && !wr_l2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            addr_reg         <= '0;
            we_reg           <= 1'b0;
            wdata_reg        <= '0;
            replay_reg       <= 1'b0;
            ready_reg        <= 1'b1;
            resp_valid_reg   <= 1'b0;
            rdata_reg        <= '0;
            wr_l2_reg        <= 1'b0;
            wr_cpu_reg       <= 1'b0;
            tag_update_reg   <= '0;
            fill_data_reg    <= '0;
            arr_wdata_reg    <= '0;
            l2_req_valid_reg <= 1'b0;
            l2_req_we_reg    <= 1'b0;
            l2_addr_reg      <= '0;
            l2_wdata_reg     <= '0;
        end else begin
            // Strobes and the response are single-cycle pulses.
            resp_valid_reg <= 1'b0;
            wr_l2_reg      <= 1'b0;
            wr_cpu_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cpu_req_valid) begin
                        addr_reg   <= cpu_addr;
                        we_reg     <= cpu_req_we;
                        wdata_reg  <= cpu_wdata;
                        replay_reg <= 1'b0;
                        ready_reg  <= 1'b0;
                        state_reg  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (lookup_active) begin
                        if (hit) begin
                            if (we_reg) begin
                                wr_cpu_reg     <= 1'b1;
                                tag_update_reg <= {1'b1, 1'b1, req_tag};
                                arr_wdata_reg  <= wdata_reg;
                            end else begin
                                rdata_reg <= arr_data;
                            end
                            resp_valid_reg <= 1'b1;
                            state_reg      <= ST_RESP;
                        end else begin
                            l2_req_valid_reg <= 1'b1;
                            if (old_dirty) begin
                                l2_req_we_reg <= 1'b1;
                                l2_addr_reg   <= {old_tag, req_idx, 2'b00};
                                l2_wdata_reg  <= arr_data;
                                state_reg     <= ST_WRBACK;
                            end else begin
                                l2_req_we_reg <= 1'b0;
                                l2_addr_reg   <= {req_tag, req_idx, 2'b00};
                                state_reg     <= ST_REFILL;
                            end
                        end
                    end
                end
                ST_WRBACK: begin
                    if (l2_ack) begin
                        l2_req_we_reg <= 1'b0;
                        l2_addr_reg   <= {req_tag, req_idx, 2'b00};
                        state_reg     <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (l2_ack) begin
                        l2_req_valid_reg <= 1'b0;
                        wr_l2_reg        <= 1'b1;
                        fill_data_reg    <= l2_rdata;
                        tag_update_reg   <= {1'b1, 1'b0, req_tag};
                        replay_reg       <= 1'b1;
                        state_reg        <= ST_LOOKUP;
                    end
                end
                ST_RESP: begin
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Statistics: index 0 counts first-pass hits, index 1 counts misses.
    logic [1:0]  cnt_inc;
    logic [15:0] cnt_val [2];

    assign cnt_inc[0] = lookup_active && hit && !replay_reg;
    assign cnt_inc[1] = lookup_active && !hit;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            l1_sat_counter u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign hit_cnt        = cnt_val[0];
    assign miss_cnt       = cnt_val[1];
    assign cpu_req_ready  = ready_reg;
    assign cpu_resp_valid = resp_valid_reg;
    assign cpu_rdata      = rdata_reg;
    assign arr_addr       = addr_reg;
    assign arr_wr_l2      = wr_l2_reg;
    assign arr_wr_cpu     = wr_cpu_reg;
    assign arr_tag_update = tag_update_reg;
    assign arr_fill_data  = fill_data_reg;
    assign arr_wdata      = arr_wdata_reg;
    assign l2_req_valid   = l2_req_valid_reg;
    assign l2_req_we      = l2_req_we_reg;
    assign l2_addr        = l2_addr_reg;
    assign l2_wdata       = l2_wdata_reg;

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Bench for l1_cache_ctrl: a behavioural tag/data array, an L2 responder with
// random latency, a directed vector table, hand-written reset/stray-ack and
// counter-saturation sequences, and a randomized run checked against a flat
// memory + direct-mapped residency model.
`timescale 1ns/1ps
module tb_l1_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_req_we;
    logic [31:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic        cpu_req_ready;
    logic        cpu_resp_valid;
    logic [63:0] cpu_rdata;
    logic [31:0] arr_addr;
    logic [23:0] arr_tag_valid_dirty;
    logic [63:0] arr_data;
    logic        arr_wr_l2;
    logic        arr_wr_cpu;
    logic [23:0] arr_tag_update;
    logic [63:0] arr_fill_data;
    logic [63:0] arr_wdata;
    logic        l2_req_valid;
    logic        l2_req_we;
    logic [31:0] l2_addr;
    logic [63:0] l2_wdata;
    logic        l2_ack;
    logic [63:0] l2_rdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    logic        sat_inc = 1'b0;
    logic [15:0] sat_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l1_cache_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .cpu_req_valid       (cpu_req_valid),
        .cpu_req_we          (cpu_req_we),
        .cpu_addr            (cpu_addr),
        .cpu_wdata           (cpu_wdata),
        .cpu_req_ready       (cpu_req_ready),
        .cpu_resp_valid      (cpu_resp_valid),
        .cpu_rdata           (cpu_rdata),
        .arr_addr            (arr_addr),
        .arr_tag_valid_dirty (arr_tag_valid_dirty),
        .arr_data            (arr_data),
        .arr_wr_l2           (arr_wr_l2),
        .arr_wr_cpu          (arr_wr_cpu),
        .arr_tag_update      (arr_tag_update),
        .arr_fill_data       (arr_fill_data),
        .arr_wdata           (arr_wdata),
        .l2_req_valid        (l2_req_valid),
        .l2_req_we           (l2_req_we),
        .l2_addr             (l2_addr),
        .l2_wdata            (l2_wdata),
        .l2_ack              (l2_ack),
        .l2_rdata            (l2_rdata),
        .hit_cnt             (hit_cnt),
        .miss_cnt            (miss_cnt)
    );

    // Stand-alone counter instance so saturation is reachable in few cycles.
    l1_sat_counter u_sat (
        .clk   (clk),
        .rst   (rst),
        .inc   (sat_inc),
        .count (sat_count)
    );

    // ---------------- L1 array model ----------------
    logic [23:0] tag_mem  [256];
    logic [63:0] data_mem [256];

    assign arr_tag_valid_dirty = tag_mem[arr_addr[9:2]];
    assign arr_data            = data_mem[arr_addr[9:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else if (arr_wr_l2) begin
            tag_mem[arr_addr[9:2]]  <= arr_tag_update;
            data_mem[arr_addr[9:2]] <= arr_fill_data;
        end else if (arr_wr_cpu) begin
            tag_mem[arr_addr[9:2]]  <= arr_tag_update;
            data_mem[arr_addr[9:2]] <= arr_wdata;
        end
    end

    // ---------------- L2 model ----------------
    function automatic logic [63:0] l2_default(input logic [31:0] line);
        if (line == 32'h0000_0404) return 64'hAAAA_AAAA_AAAA_AAAA;
        return {line ^ 32'hC0DE_5A5A, line};
    endfunction

    logic [63:0] l2_mem [logic [31:0]];
    int          ev_n = 0;
    logic        ev_we   [1024];
    logic [31:0] ev_addr [1024];
    logic [63:0] ev_data [1024];
    bit          l2_hold    = 1'b0;
    int          stray_want = 0;
    int          stray_done = 0;

    initial begin : l2_responder
        int delay;
        l2_ack   = 1'b0;
        l2_rdata = '0;
        delay    = 1;
        forever begin
            @(negedge clk);
            if (l2_ack) begin
                l2_ack = 1'b0;
            end else if (stray_want != stray_done) begin
                stray_done++;
                l2_ack   = 1'b1;
                l2_rdata = 64'hDEAD_BEEF_0BAD_F00D;
            end else if (l2_req_valid && !l2_hold && !rst) begin
                if (delay > 0) begin
                    delay--;
                end else begin
                    ev_we[ev_n % 1024]   = l2_req_we;
                    ev_addr[ev_n % 1024] = l2_addr;
                    ev_data[ev_n % 1024] = l2_wdata;
                    ev_n++;
                    if (l2_req_we) l2_mem[l2_addr] = l2_wdata;
                    else l2_rdata = l2_mem.exists(l2_addr) ? l2_mem[l2_addr] : l2_default(l2_addr);
                    l2_ack = 1'b1;
                    delay  = $urandom_range(0, 3);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [63:0] ref_mem [logic [31:0]];
    bit          ref_valid [256];
    logic [21:0] ref_tag   [256];
    int          ref_hits   = 0;
    int          ref_misses = 0;

    function automatic void ref_access(input logic we, input logic [31:0] addr,
                                       input logic [63:0] wd,
                                       output logic [63:0] rd, output bit is_hit);
        logic [31:0] line;
        int          idx;
        line   = {addr[31:2], 2'b00};
        idx    = int'(addr[9:2]);
        is_hit = ref_valid[idx] && (ref_tag[idx] == addr[31:10]);
        rd     = ref_mem.exists(line) ? ref_mem[line] : l2_default(line);
        if (we) ref_mem[line] = wd;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = addr[31:10];
        if (is_hit) begin
            if (ref_hits < 65535) ref_hits++;
        end else begin
            if (ref_misses < 65535) ref_misses++;
        end
    endfunction

    function automatic void ref_reset();
        for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // One CPU transaction, started and finished on a falling edge.
    // lat counts falling edges after the accepting rising edge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                          output logic [63:0] rd, output int lat,
                          output logic [23:0] cpu_tag, output bit both_strobes, output bit ok);
        int n;
        ok = 1'b1; rd = '0; lat = 0; cpu_tag = '0; both_strobes = 1'b0;
        n = 0;
        while (!cpu_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_req_ready) begin
            ok = 1'b0;
            return;
        end
        cpu_req_valid = 1'b1; cpu_req_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        lat = 1;
        while (lat < 200) begin
            if (arr_wr_l2 && arr_wr_cpu) both_strobes = 1'b1;
            if (arr_wr_cpu) cpu_tag = arr_tag_update;
            if (cpu_resp_valid) begin
                rd = cpu_rdata;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!cpu_resp_valid) ok = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        int          exp_lat;    // 0 = latency not checked
        logic [23:0] exp_tag;    // checked on writes
        int          exp_hits;
        int          exp_misses;
        int          exp_l2;     // L2 transactions issued
    } vec_t;

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        vecs[5];
        logic [63:0] rd, exp_rd;
        logic [23:0] ctag;
        logic [31:0] a;
        logic [63:0] wd;
        logic        we;
        int          lat, ev0, n;
        bit          ok, both, is_hit, saw_fill;

        vecs[0] = '{1'b0, 32'h0000_0404, 64'h0,    64'hAAAA_AAAA_AAAA_AAAA, 0, 24'h0,      0, 1, 1};
        vecs[1] = '{1'b0, 32'h0000_0404, 64'h0,    64'hAAAA_AAAA_AAAA_AAAA, 2, 24'h0,      1, 1, 0};
        vecs[2] = '{1'b1, 32'h0000_0404, 64'h1234, 64'h0,                   2, 24'hC00001, 2, 1, 0};
        vecs[3] = '{1'b0, 32'h0000_0804, 64'h0,    l2_default(32'h804),     0, 24'h0,      2, 2, 2};
        vecs[4] = '{1'b0, 32'h0000_0404, 64'h0,    64'h1234,                0, 24'h0,      2, 3, 1};

        rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ref_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready",      64'(cpu_req_ready), 64'd1);
        check("reset_resp_valid", 64'(cpu_resp_valid), 64'd0);
        check("reset_l2_valid",   64'(l2_req_valid), 64'd0);
        check("reset_strobes",    64'({arr_wr_l2, arr_wr_cpu}), 64'd0);
        check("reset_rdata",      cpu_rdata, 64'd0);
        check("reset_counters",   64'({hit_cnt, miss_cnt}), 64'd0);
        check("reset_arr_addr",   64'(arr_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 5; i++) begin
            ev0 = ev_n;
            ref_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, exp_rd, is_hit);
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, ctag, both, ok);
            check($sformatf("vec%0d_done", i), 64'(ok), 64'd1);
            check($sformatf("vec%0d_strobe_excl", i), 64'(both), 64'd0);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            if (vecs[i].we) check($sformatf("vec%0d_tag_update", i), 64'(ctag), 64'(vecs[i].exp_tag));
            if (vecs[i].exp_lat != 0) check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_hit_cnt", i), 64'(hit_cnt), 64'(vecs[i].exp_hits));
            check($sformatf("vec%0d_miss_cnt", i), 64'(miss_cnt), 64'(vecs[i].exp_misses));
            check($sformatf("vec%0d_l2_count", i), 64'(ev_n - ev0), 64'(vecs[i].exp_l2));
            if (i == 3) begin
                check("vec3_wb_we",     64'(ev_we[ev0 % 1024]), 64'd1);
                check("vec3_wb_addr",   64'(ev_addr[ev0 % 1024]), 64'h404);
                check("vec3_wb_data",   ev_data[ev0 % 1024], 64'h1234);
                check("vec3_fill_we",   64'(ev_we[(ev0 + 1) % 1024]), 64'd0);
                check("vec3_fill_addr", 64'(ev_addr[(ev0 + 1) % 1024]), 64'h804);
            end
            $display("vec %0d we=%0d addr=%h rdata=%h lat=%0d hit_cnt=%0d miss_cnt=%0d",
                     i, vecs[i].we, vecs[i].addr, rd, lat, hit_cnt, miss_cnt);
        end

        // Reset while a refill is outstanding, then a stray acknowledge.
        l2_hold = 1'b1;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_addr = 32'h0000_0C08;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        n = 0;
        while (!l2_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstseq_refill_valid", 64'(l2_req_valid), 64'd1);
        check("rstseq_refill_we",    64'(l2_req_we), 64'd0);
        check("rstseq_refill_addr",  64'(l2_addr), 64'h0C08);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstseq_l2_dropped", 64'(l2_req_valid), 64'd0);
        check("rstseq_ready",      64'(cpu_req_ready), 64'd1);
        rst = 1'b0;
        l2_hold = 1'b0;
        ref_reset();
        stray_want++;
        saw_fill = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (arr_wr_l2 || arr_wr_cpu) saw_fill = 1'b1;
        end
        check("stray_ack_no_write", 64'(saw_fill), 64'd0);
        check("stray_ack_ready",    64'(cpu_req_ready), 64'd1);
        check("stray_ack_counters", 64'({hit_cnt, miss_cnt}), 64'd0);
        $display("reset/stray-ack sequence: l2_req_valid=%0d ready=%0d", l2_req_valid, cpu_req_ready);

        // Randomized traffic on a few indices/tags so hits, clean and dirty
        // evictions all occur.
        for (int t = 0; t < 200; t++) begin
            a  = {22'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            we = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            ref_access(we, a, wd, exp_rd, is_hit);
            do_req(we, a, wd, rd, lat, ctag, both, ok);
            check("rnd_done", 64'(ok), 64'd1);
            check("rnd_strobe_excl", 64'(both), 64'd0);
            if (!we) check("rnd_rdata", rd, exp_rd);
            if (is_hit) check("rnd_hit_latency", 64'(lat), 64'd2);
            check("rnd_hit_cnt",  64'(hit_cnt), 64'(ref_hits));
            check("rnd_miss_cnt", 64'(miss_cnt), 64'(ref_misses));
            $display("txn %0d we=%0d addr=%h wdata=%h rdata=%h hit=%0d lat=%0d",
                     t, we, a, wd, rd, is_hit, lat);
        end

        // Saturation of the statistics counter.
        @(negedge clk);
        check("sat_start", 64'(sat_count), 64'd0);
        sat_inc = 1'b1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("sat_near_top", 64'(sat_count), 64'hFFFE);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("sat_hold", 64'(sat_count), 64'hFFFF);
        sat_inc = 1'b0;
        $display("saturation sequence: count=%h", sat_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
